arith_mon: RTL
==============

# arith_mon

Parametrised scoreboard monitor for the arithmetic testbench. It computes a golden result for add, subtract, reverse-subtract or multiply, delays it to match a DUT of configurable pipeline latency, and compares it against the DUT output. It accumulates sample and mismatch counts, captures the first failing vector, and reports pass/fail at the end of a bounded run. It sits beside the DUT and is driven by the same stimulus generator.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width
- `LAT`, 1, DUT latency in cycles from `i_valid` to `i_dut_valid` (legal range ≥ 1)
- `CNT_W`, 16, width of the counters and of `i_n_samples`

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `i_start` in 1: begin a run (IDLE only)
- `i_clear` in 1: abort and return to IDLE, clearing counters and capture
- `i_n_samples` in CNT_W: samples to check per run; sampled on start
- `i_valid` in 1: stimulus valid
- `i_op` in 2: 0 a+b, 1 a−b, 2 b−a, 3 low WIDTH bits of a·b
- `i_a`, `i_b` in WIDTH: operands
- `i_dut_valid` in 1: DUT result valid
- `i_dut_o` in WIDTH: DUT result
- `o_mon_o` out WIDTH: registered golden result of the last compare
- `o_dtm_o` out WIDTH: registered DUT result of the last compare
- `o_busy`, `o_done`, `o_pass` out 1: run status
- `o_n_checked`, `o_n_err`, `o_n_proto` out CNT_W: counters
- `o_fail_a`, `o_fail_b`, `o_fail_exp`, `o_fail_got` out WIDTH: first-failure capture
- `o_fail_op` out 2: opcode of the first failure

## Operation
- FSM states: IDLE → RUN on `i_start`. RUN → DONE when `o_n_checked` reaches the latched sample count. Any state → IDLE on `i_clear`. DONE → RUN on `i_start`.
- `i_clear` has priority over `i_start`. Entering RUN zeroes all counters and the capture registers.
- A latched sample count of 0 goes RUN → DONE on the next cycle, with `o_pass`=1.
- Golden arithmetic is modulo 2^WIDTH. Subtract wraps, and multiply keeps the low WIDTH bits.
- Stimulus enters the delay line only while in RUN with `i_valid`=1. The line is LAT stages of {valid, op, a, b, expected}.
- Compare event: delayed valid and `i_dut_valid` both high, in RUN. Increment `o_n_checked`. If `i_dut_o` differs from expected, increment `o_n_err`. On the first error, also load the capture registers.
- Exactly one of delayed valid or `i_dut_valid` high, in RUN: increment `o_n_proto`. No compare takes place.
- All counters saturate at 2^CNT_W−1.
- `o_pass` is 1 in DONE only when `o_n_err`=0 and `o_n_proto`=0. It is 0 elsewhere.
- Samples still in flight when RUN → DONE are discarded. `i_clear` flushes the delay line.

## Timing
- Stimulus at cycle t is compared at cycle t+LAT. `o_mon_o`, `o_dtm_o` and the counters update at the edge ending that cycle, so they are visible at t+LAT+1.
- `o_done` and `o_busy` are registered state decodes. `o_done` rises the cycle after the final compare.
- Reset (async) puts the FSM in IDLE. Every output and every delay-line stage goes to 0.
- Reset mid-run discards all in-flight state.

## Configuration
- `ARITH_MON_ERR_INJ_EN` defined: when a[0]=1 and b[0]=1, expected = b instead of the golden result. This injects a 25% error rate on random stimulus so the checker can be checked.
- Macro undefined: expected is always the true golden result.

## Structure
- `arith_mon_pkg`: op encoding localparams (`OP_ADD`, `OP_SUB`, `OP_RSUB`, `OP_MUL`) and FSM state typedef (`ST_IDLE`, `ST_RUN`, `ST_DONE`).
- Sub-module `arith_mon_model`: combinational golden function plus the error-inject hook, parameterised on `WIDTH`. The top holds the FSM, delay line, counters and capture.

## Test plan
- WIDTH=32, LAT=3, n=4. Add 5+7, sub 3−5, rsub 3−5, mul 0x10000·0x10000; DUT correct. Response: expected 12, 0xFFFFFFFE, 2, 0; `o_n_checked`=4, DONE, `o_pass`=1.
- Same run with DUT returning 13 for 5+7. Response: `o_n_err`=1, capture a=5, b=7, exp=12, got=13, op=0; `o_pass`=0.
- Drop one `i_dut_valid`. Response: `o_n_proto`=1, `o_pass`=0, run completes after the remaining matching compares.
- With `ARITH_MON_ERR_INJ_EN`: a=3, b=5, op add, DUT returns 8. Response: expected 5, `o_n_err`=1.
- Assert `i_clear` and `i_start` in the same cycle mid-run. Response: IDLE next cycle, counters 0, in-flight results ignored.
- CNT_W=4 with 20 mismatching samples. Response: `o_n_err` saturates at 15.

Source files
------------

// File: rtl/arith_mon_pkg.sv
// rtl/arith_mon_pkg.sv - opcode encoding and run-state type shared by the arith_mon block
package arith_mon_pkg;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_RSUB = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arith_mon_model.sv
// rtl/arith_mon_model.sv - combinational golden arithmetic (modulo 2^WIDTH)
// ARITH_MON_ERR_INJ_EN: when a[0] and b[0] are both set, expected is forced to b.
module arith_mon_model
  import arith_mon_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);

  logic [WIDTH-1:0] golden;

  always_comb begin
    golden = '0;
    case (op)
      OP_ADD:  golden = a + b;
      OP_SUB:  golden = a - b;
      OP_RSUB: golden = b - a;
      OP_MUL:  golden = a * b;
      default: golden = '0;
    endcase
  end

`ifdef ARITH_MON_ERR_INJ_EN
  // Deliberately wrong on ~25% of random stimulus so the checker itself can be exercised.
  assign expected = (a[0] && b[0]) ? b : golden;
`else
  assign expected = golden;
`endif

endmodule

// File: rtl/arith_mon.sv
// rtl/arith_mon.sv - scoreboard monitor: golden model, LAT-deep delay line, counters, first-fail capture
// Optional error injection in arith_mon_model via ARITH_MON_ERR_INJ_EN.
module arith_mon
  import arith_mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_n_samples,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_dut_valid,
  input  logic [WIDTH-1:0] i_dut_o,
  output logic [WIDTH-1:0] o_mon_o,
  output logic [WIDTH-1:0] o_dtm_o,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_n_checked,
  output logic [CNT_W-1:0] o_n_err,
  output logic [CNT_W-1:0] o_n_proto,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic [WIDTH-1:0] o_fail_exp,
  output logic [WIDTH-1:0] o_fail_got,
  output logic [1:0]       o_fail_op
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_target;
  logic [WIDTH-1:0] expected;
  logic [LAT-1:0]   dl_valid;
  logic [1:0]       dl_op  [LAT];
  logic [WIDTH-1:0] dl_a   [LAT];
  logic [WIDTH-1:0] dl_b   [LAT];
  logic [WIDTH-1:0] dl_exp [LAT];
  logic             run, stay_run, enter_run, cmp, proto, mismatch;
  logic [CNT_W-1:0] checked_next;

  arith_mon_model #(.WIDTH(WIDTH)) u_model (
    .op(i_op), .a(i_a), .b(i_b), .expected(expected)
  );

  assign run          = (state_q == ST_RUN);
  assign stay_run     = (state_d == ST_RUN);
  assign enter_run    = !run && stay_run;
  assign cmp          = run && dl_valid[LAT-1] && i_dut_valid;
  assign proto        = run && (dl_valid[LAT-1] != i_dut_valid);
  assign mismatch     = (i_dut_o != dl_exp[LAT-1]);
  // Looking at the post-increment count lets DONE land on the edge of the final compare.
  assign checked_next = (cmp && o_n_checked != CNT_MAX) ? o_n_checked + 1'b1 : o_n_checked;

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (i_start) state_d = ST_RUN;
        ST_RUN:           if (checked_next >= n_target) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      n_target <= '0;
    end else begin
      state_q <= state_d;
      if (enter_run) n_target <= i_n_samples;
    end
  end

  assign o_busy = (state_q == ST_RUN);
  assign o_done = (state_q == ST_DONE);
  assign o_pass = o_done && (o_n_err == '0) && (o_n_proto == '0);

  // Any exit from RUN (done or clear) flushes in-flight samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_valid <= '0;
      for (int i = 0; i < LAT; i++) begin
        dl_op[i]  <= '0;
        dl_a[i]   <= '0;
        dl_b[i]   <= '0;
        dl_exp[i] <= '0;
      end
    end else begin
      dl_valid[0] <= run && stay_run && i_valid;
      dl_op[0]    <= i_op;
      dl_a[0]     <= i_a;
      dl_b[0]     <= i_b;
      dl_exp[0]   <= expected;
      for (int i = 1; i < LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1] && stay_run;
        dl_op[i]    <= dl_op[i-1];
        dl_a[i]     <= dl_a[i-1];
        dl_b[i]     <= dl_b[i-1];
        dl_exp[i]   <= dl_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_mon_o <= '0;  o_dtm_o <= '0;
      o_n_checked <= '0;  o_n_err <= '0;  o_n_proto <= '0;
      o_fail_a <= '0;  o_fail_b <= '0;  o_fail_exp <= '0;  o_fail_got <= '0;  o_fail_op <= '0;
    end else if (i_clear || enter_run) begin
      o_mon_o <= '0;  o_dtm_o <= '0;
      o_n_checked <= '0;  o_n_err <= '0;  o_n_proto <= '0;
      o_fail_a <= '0;  o_fail_b <= '0;  o_fail_exp <= '0;  o_fail_got <= '0;  o_fail_op <= '0;
    end else if (cmp) begin
      o_mon_o     <= dl_exp[LAT-1];
      o_dtm_o     <= i_dut_o;
      o_n_checked <= checked_next;
      if (mismatch) begin
        if (o_n_err != CNT_MAX) o_n_err <= o_n_err + 1'b1;
        if (o_n_err == '0) begin
          o_fail_a   <= dl_a[LAT-1];
          o_fail_b   <= dl_b[LAT-1];
          o_fail_exp <= dl_exp[LAT-1];
          o_fail_got <= i_dut_o;
          o_fail_op  <= dl_op[LAT-1];
        end
      end
    end else if (proto && o_n_proto != CNT_MAX) begin
      o_n_proto <= o_n_proto + 1'b1;
    end
  end

endmodule
